// File: rtl/core7_cpu_ocimem_ctrl_pkg.sv
// core7_ocimem_pkg: shared types and jdo field positions for the OCI debug
// memory controller.
//   state_e       controller FSM states
//   ADDR_LSB      lowest jdo bit of the JTAG word address
//   RDREQ_BIT     jdo bit requesting a read on an address load
//   WDATA_MSB/LSB jdo slice carrying JTAG write data
package core7_ocimem_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    JT_RD   = 3'd1,
    JT_RD_D = 3'd2,
    JT_WR   = 3'd3,
    AV_RD   = 3'd4
  } state_e;

  localparam int ADDR_LSB  = 2;
  localparam int RDREQ_BIT = 34;
  localparam int WDATA_MSB = 34;
  localparam int WDATA_LSB = 3;

endpackage

// File: rtl/core7_cpu_ocimem_ctrl_if.sv
// core7_cpu_ocimem_ctrl_if: Avalon-MM debug slave bus between the CPU side
// (master) and the OCI memory controller (slave).
//   avs_address/read/write/writedata/byteenable  request, master -> slave
//   avs_readdata/waitrequest                      response, slave -> master
interface core7_cpu_ocimem_ctrl_if #(
  parameter int ADDR_W = 8
) ();

  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata, avs_waitrequest
  );

endinterface

// File: rtl/core7_cpu_ocimem_ram.sv
// core7_cpu_ocimem_ram: single-port synchronous debug RAM, 32-bit words with
// byte enables, one-cycle read latency. Contents are not reset.
//   clk       clock
//   en_i      access enable
//   we_i      write (else read) when enabled
//   be_i      byte lanes for writes
//   addr_i    word address
//   wdata_i   write data
//   rdata_o   read data, valid the cycle after a read; held otherwise
module core7_cpu_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [0:(1<<ADDR_W)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < 4; i++) begin
          if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/core7_cpu_ocimem_ctrl.sv
// core7_cpu_ocimem_ctrl: OCI debug memory controller. Decodes JTAG ocimem
// strobes into reads/writes of the debug RAM at MonAReg (with optional
// post-increment) and arbitrates them, with priority, against Avalon CPU
// accesses.
//   clk, reset_n             clock, asynchronous active-low reset
//   jdo                      JTAG data, sampled on strobe cycles only
//   take_action_ocimem_a     address load, optional read (jdo[34])
//   take_no_action_ocimem_a  read at MonAReg, post-increment
//   take_action_ocimem_b     write jdo[34:3] at MonAReg, post-increment
//   MonDReg                  last JTAG read data
//   monitor_ready            no JTAG access pending or in flight
//   jtag_overrun             sticky: strobe dropped because JTAG was busy
//   avs                      Avalon-MM slave bus
module core7_cpu_ocimem_ctrl
  import core7_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_no_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        jtag_overrun,
  core7_cpu_ocimem_ctrl_if.slave avs
);

  state_e            state_q;
  logic [ADDR_W-1:0] mon_a_q;
  logic [31:0]       mon_d_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdhold_q;
  logic              rd_pend_q, wr_pend_q, inc_q;
  logic              ready_q, overrun_q;

  logic              ram_en, ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;
  logic              av_accept, av_rd_go;

  logic strobe, jtag_busy, avs_free;
  assign strobe    = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign jtag_busy = rd_pend_q | wr_pend_q;
  // An arriving strobe already counts as JTAG demand, so a same-cycle
  // Avalon request is held off and the JTAG access goes first.
  assign avs_free  = (state_q == IDLE) && !jtag_busy && !strobe;
  assign av_rd_go  = avs_free && !avs.avs_write && avs.avs_read;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:35], jdo[1:0]};

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = 4'hF;
    ram_addr  = mon_a_q;
    ram_wdata = wdata_q;
    av_accept = 1'b0;
    case (state_q)
      IDLE: begin
        if (avs_free && avs.avs_write) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_be    = avs.avs_byteenable;
          ram_addr  = avs.avs_address;
          ram_wdata = avs.avs_writedata;
          av_accept = 1'b1;
        end else if (av_rd_go) begin
          ram_en   = 1'b1;
          ram_addr = avs.avs_address;
        end
      end
      JT_RD: ram_en = 1'b1;
      JT_WR: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
      end
      AV_RD: av_accept = avs.avs_read;
      default: ;
    endcase
  end

  core7_cpu_ocimem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mon_a_q   <= '0;
      mon_d_q   <= '0;
      wdata_q   <= '0;
      rdhold_q  <= '0;
      rd_pend_q <= 1'b0;
      wr_pend_q <= 1'b0;
      inc_q     <= 1'b0;
      ready_q   <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      // Strobe decode; while busy the strobe is dropped entirely.
      if (strobe) begin
        if (jtag_busy) begin
          overrun_q <= 1'b1;
        end else if (take_action_ocimem_a) begin
          mon_a_q   <= jdo[ADDR_LSB +: ADDR_W];
          rd_pend_q <= jdo[RDREQ_BIT];
          inc_q     <= 1'b0;
        end else if (take_no_action_ocimem_a) begin
          rd_pend_q <= 1'b1;
          inc_q     <= 1'b1;
        end else begin
          wdata_q   <= jdo[WDATA_MSB:WDATA_LSB];
          wr_pend_q <= 1'b1;
          inc_q     <= 1'b1;
        end
      end

      ready_q <= !jtag_busy;

      // Pend clears below only happen while busy, so they never collide
      // with the strobe decode above.
      case (state_q)
        IDLE: begin
          if (rd_pend_q)      state_q <= JT_RD;
          else if (wr_pend_q) state_q <= JT_WR;
          else if (av_rd_go)  state_q <= AV_RD;
        end
        JT_RD: state_q <= JT_RD_D;
        JT_RD_D: begin
          mon_d_q   <= ram_rdata;
          if (inc_q) mon_a_q <= mon_a_q + 1'b1;
          rd_pend_q <= 1'b0;
          inc_q     <= 1'b0;
          state_q   <= IDLE;
        end
        JT_WR: begin
          if (inc_q) mon_a_q <= mon_a_q + 1'b1;
          wr_pend_q <= 1'b0;
          inc_q     <= 1'b0;
          state_q   <= IDLE;
        end
        AV_RD: begin
          rdhold_q <= ram_rdata;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign jtag_overrun  = overrun_q;

  // The RAM output register supplies data in the acknowledge cycle; the hold
  // register keeps it visible until the next read.
  assign avs.avs_readdata    = (state_q == AV_RD) ? ram_rdata : rdhold_q;
  assign avs.avs_waitrequest = (avs.avs_read | avs.avs_write) && !av_accept;

endmodule

// File: tb/tb_core7_cpu_ocimem_ctrl.sv
// Bench for core7_cpu_ocimem_ctrl: reference memory model plus JTAG and
// Avalon result queues checked as the DUT delivers data.
module tb_core7_cpu_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        st_a, st_na, st_b;
  logic [31:0] MonDReg;
  logic        monitor_ready, jtag_overrun;

  core7_cpu_ocimem_ctrl_if #(.ADDR_W(8)) avs_bus ();

  core7_cpu_ocimem_ctrl #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (st_a),
    .take_no_action_ocimem_a (st_na),
    .take_action_ocimem_b    (st_b),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .jtag_overrun            (jtag_overrun),
    .avs                     (avs_bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] model [0:255];
  logic [7:0]  mon_a = 8'h00;
  logic [31:0] jt_q [$];
  logic [31:0] av_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd);
    logic [37:0] j;
    j = '0;
    j[9:2] = addr;
    j[34]  = rd;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [37:0] j;
    j = '0;
    j[34:3] = data;
    return j;
  endfunction

  // kind: 0 = ocimem_a, 1 = no_action_ocimem_a, 2 = ocimem_b
  task automatic jt_strobe(input int kind, input logic [37:0] d);
    jdo   = d;
    st_a  = (kind == 0);
    st_na = (kind == 1);
    st_b  = (kind == 2);
    tick();
    st_a = 1'b0; st_na = 1'b0; st_b = 1'b0;
    jdo  = '0;
  endtask

  task automatic jt_wait(input bit has_rd);
    bit ok;
    ok = 1'b0;
    tick();
    for (int n = 0; n < 20; n++) begin
      if (monitor_ready) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) chk("jt_timeout", 32'd0, 32'd1);
    else if (has_rd) begin
      if (jt_q.size() == 0) chk("jt_queue_empty", 32'd0, 32'd1);
      else chk("MonDReg", MonDReg, jt_q.pop_front());
    end
  endtask

  task automatic jt_load(input logic [7:0] addr, input logic rd);
    if (rd) jt_q.push_back(model[addr]);
    mon_a = addr;
    jt_strobe(0, jdo_a(addr, rd));
    jt_wait(rd);
  endtask

  task automatic jt_read_inc();
    jt_q.push_back(model[mon_a]);
    mon_a = mon_a + 8'd1;
    jt_strobe(1, '0);
    jt_wait(1'b1);
  endtask

  task automatic jt_write(input logic [31:0] data);
    model[mon_a] = data;
    mon_a = mon_a + 8'd1;
    jt_strobe(2, jdo_b(data));
    jt_wait(1'b0);
  endtask

  // Assumes the request is already driven; waits for acceptance, then drops it.
  task automatic av_poll(input bit wr, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!avs_bus.avs_waitrequest) begin
        ok = 1'b1;
        if (!wr) begin
          if (av_q.size() == 0) chk("av_queue_empty", 32'd0, 32'd1);
          else chk("avs_readdata", avs_bus.avs_readdata, av_q.pop_front());
        end
        break;
      end
      waits++;
      @(posedge clk);
    end
    if (!ok) chk("av_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    avs_bus.avs_read  = 1'b0;
    avs_bus.avs_write = 1'b0;
  endtask

  task automatic av_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] data,
                         input logic [3:0] be, output int waits);
    if (wr) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) model[addr][8*i +: 8] = data[8*i +: 8];
    end else begin
      av_q.push_back(model[addr]);
    end
    avs_bus.avs_address    = addr;
    avs_bus.avs_writedata  = data;
    avs_bus.avs_byteenable = be;
    avs_bus.avs_write      = wr;
    avs_bus.avs_read       = !wr;
    av_poll(wr, waits);
  endtask

  initial begin
    int w;
    reset_n = 1'b0;
    jdo = '0; st_a = 1'b0; st_na = 1'b0; st_b = 1'b0;
    avs_bus.avs_address = '0; avs_bus.avs_read = 1'b0; avs_bus.avs_write = 1'b0;
    avs_bus.avs_writedata = '0; avs_bus.avs_byteenable = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_ready", {31'd0, monitor_ready}, 32'd1);
    chk("rst_MonDReg", MonDReg, 32'd0);
    chk("rst_overrun", {31'd0, jtag_overrun}, 32'd0);
    chk("rst_waitreq", {31'd0, avs_bus.avs_waitrequest}, 32'd0);
    chk("rst_readdata", avs_bus.avs_readdata, 32'd0);
    tick();

    // Address load, two writes, then read back with 3-clk latency
    jt_load(8'h10, 1'b0);
    jt_write(32'hDEADBEEF);
    jt_write(32'hCAFEF00D);
    av_xfer(1'b0, 8'h11, '0, 4'hF, w);
    av_xfer(1'b0, 8'h10, '0, 4'hF, w);
    jt_q.push_back(model[8'h10]);
    mon_a = 8'h10;
    jt_strobe(0, jdo_a(8'h10, 1'b1));
    tick();
    chk("ready_low", {31'd0, monitor_ready}, 32'd0);
    tick();
    chk("lat_early", MonDReg, 32'd0);
    tick();
    chk("lat_3clk", MonDReg, jt_q.pop_front());
    jt_wait(1'b0);

    // Wrap-around of MonAReg
    av_xfer(1'b1, 8'hFF, 32'h0000FFFF, 4'hF, w);
    av_xfer(1'b1, 8'h00, 32'h00000000, 4'hF, w);
    av_xfer(1'b1, 8'h01, 32'h11111111, 4'hF, w);
    jt_load(8'hFF, 1'b0);
    jt_read_inc();
    jt_read_inc();
    jt_write(32'h0BEEF001);
    av_xfer(1'b0, 8'h01, '0, 4'hF, w);
    av_xfer(1'b0, 8'h00, '0, 4'hF, w);

    // Avalon byte-enabled write and read latency
    av_xfer(1'b1, 8'h05, 32'hAAAAAAAA, 4'hF, w);
    chk("av_wr_wait", w, 32'd0);
    av_xfer(1'b1, 8'h05, 32'h12345678, 4'b0011, w);
    av_xfer(1'b0, 8'h05, '0, 4'hF, w);
    chk("av_rd_wait", w, 32'd1);
    chk("av_be_merge", model[8'h05], 32'hAAAA5678);

    // Contention: JTAG write and Avalon read in the same cycle
    jt_load(8'h20, 1'b0);
    model[8'h20] = 32'h5A5A0F0F;
    mon_a = 8'h21;
    av_q.push_back(model[8'h20]);
    jdo = jdo_b(32'h5A5A0F0F);
    st_b = 1'b1;
    avs_bus.avs_address = 8'h20;
    avs_bus.avs_read    = 1'b1;
    @(negedge clk);
    chk("cont_stall", {31'd0, avs_bus.avs_waitrequest}, 32'd1);
    @(posedge clk);
    #1;
    st_b = 1'b0;
    jdo  = '0;
    av_poll(1'b0, w);
    chk("cont_extra_stall", {31'd0, (w + 1) > 1}, 32'd1);
    jt_wait(1'b0);

    // Overrun: second strobe while a read is pending
    chk("ovr_clear", {31'd0, jtag_overrun}, 32'd0);
    jt_q.push_back(model[8'h05]);
    mon_a = 8'h05;
    jt_strobe(0, jdo_a(8'h05, 1'b1));
    jt_strobe(0, jdo_a(8'h30, 1'b0));
    jt_wait(1'b1);
    chk("ovr_set", {31'd0, jtag_overrun}, 32'd1);
    jt_write(32'h0BADF00D);
    av_xfer(1'b0, 8'h05, '0, 4'hF, w);
    chk("ovr_sticky", {31'd0, jtag_overrun}, 32'd1);

    // Reset in the middle of a JTAG read
    jt_strobe(0, jdo_a(8'h11, 1'b1));
    tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, monitor_ready}, 32'd1);
    chk("mid_rst_MonDReg", MonDReg, 32'd0);
    chk("mid_rst_overrun", {31'd0, jtag_overrun}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    av_xfer(1'b0, 8'h10, '0, 4'hF, w);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
